// File: rtl/dda_param_ctrl.sv
// Purpose: Avalon-MM control block that sequences the Lorenz DDA integrator and applies shadowed sigma/beta/rho atomically at step boundaries.
// Latency: register writes land on the next clk edge; a pending commit reaches the outputs one cycle after it is seen in IDLE or APPLY.
// Backpressure: none on the bus; steps are paced by step_done and the FSM holds in WAIT until it arrives.
//
// Ports:
//   clk, reset_n                  clock and asynchronous active-low reset
//   address/chipselect/write_n/
//   writedata/readdata            Avalon-MM slave (readdata is a combinational mux)
//   step_done                     one-cycle completion pulse from the datapath
//   sigma_out/beta_out/rho_out    active parameters to the datapath
//   dda_init, dda_step, running   sequencing strobes and busy flag
module dda_param_ctrl #(
  parameter int unsigned        DATA_W    = 32,
  parameter int unsigned        CNT_W     = 32,
  parameter logic [DATA_W-1:0]  SIGMA_RST = 32'h000A_0000,
  parameter logic [DATA_W-1:0]  BETA_RST  = 32'h0002_AAAA,
  parameter logic [DATA_W-1:0]  RHO_RST   = 32'h001C_0000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  input  logic              step_done,
  output logic [DATA_W-1:0] sigma_out,
  output logic [DATA_W-1:0] beta_out,
  output logic [DATA_W-1:0] rho_out,
  output logic              dda_init,
  output logic              dda_step,
  output logic              running
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_APPLY = 3'd4
  } state_t;

  localparam logic [2:0] A_CTRL   = 3'd0;
  localparam logic [2:0] A_SIGMA  = 3'd1;
  localparam logic [2:0] A_BETA   = 3'd2;
  localparam logic [2:0] A_RHO    = 3'd3;
  localparam logic [2:0] A_LIMIT  = 3'd4;
  localparam logic [2:0] A_STATUS = 3'd5;
  localparam logic [2:0] A_COUNT  = 3'd6;

  state_t             state;
  state_t             state_nxt;
  logic               run_q;
  logic               commit_pending;
  logic               reinit_pending;
  logic [DATA_W-1:0]  sigma_sh;
  logic [DATA_W-1:0]  beta_sh;
  logic [DATA_W-1:0]  rho_sh;
  logic [CNT_W-1:0]   step_limit;
  logic [CNT_W-1:0]   step_count;

  logic               wr;
  logic               wr_ctrl;
  logic               wr_step;
  logic               wr_commit;
  logic               wr_reinit;
  logic               reinit_req;
  logic               take_reinit;
  logic               limit_hit;
  logic               run_clr;
  logic               cnt_clr;
  logic               cnt_inc;
  logic               apply_now;

  assign wr        = chipselect && !write_n;
  assign wr_ctrl   = wr && (address == A_CTRL);
  assign wr_step   = wr_ctrl && writedata[1];
  assign wr_commit = wr_ctrl && writedata[2];
  assign wr_reinit = wr_ctrl && writedata[3];

  // A reinit written while a step is in flight is held until the next boundary.
  assign reinit_req = reinit_pending || wr_reinit;
  assign limit_hit  = (step_limit != '0) && (step_count == step_limit);
  // Parameters only move while the datapath is not mid-step.
  assign apply_now  = commit_pending && ((state == ST_IDLE) || (state == ST_APPLY));

  always_comb begin
    state_nxt   = state;
    take_reinit = 1'b0;
    run_clr     = 1'b0;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (reinit_req) begin
          state_nxt   = ST_INIT;
          take_reinit = 1'b1;
        end else if (run_q || wr_step) begin
          state_nxt = ST_ISSUE;
        end
      end
      ST_INIT: begin
        cnt_clr   = 1'b1;
        state_nxt = run_q ? ST_ISSUE : ST_IDLE;
      end
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (step_done) begin
          cnt_inc   = 1'b1;
          state_nxt = ST_APPLY;
        end
      end
      ST_APPLY: begin
        if (reinit_req) begin
          state_nxt   = ST_INIT;
          take_reinit = 1'b1;
        end else if (run_q && !limit_hit) begin
          state_nxt = ST_ISSUE;
        end else begin
          state_nxt = ST_IDLE;
          // Only a limit-caused stop clears run; a software stop already did.
          run_clr   = run_q && limit_hit;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Sequencer: state plus registered strobes derived from the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      dda_init <= 1'b0;
      dda_step <= 1'b0;
      running  <= 1'b0;
    end else begin
      state    <= state_nxt;
      dda_init <= (state_nxt == ST_INIT);
      dda_step <= (state_nxt == ST_ISSUE);
      running  <= (state_nxt != ST_IDLE);
    end
  end

  // Control/status registers, shadows and active parameters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q          <= 1'b0;
      commit_pending <= 1'b0;
      reinit_pending <= 1'b0;
      sigma_sh       <= SIGMA_RST;
      beta_sh        <= BETA_RST;
      rho_sh         <= RHO_RST;
      sigma_out      <= SIGMA_RST;
      beta_out       <= BETA_RST;
      rho_out        <= RHO_RST;
      step_limit     <= '0;
      step_count     <= '0;
    end else begin
      reinit_pending <= reinit_req && !take_reinit;

      if (cnt_clr) begin
        step_count <= '0;
      end else if (cnt_inc) begin
        step_count <= step_count + CNT_W'(1);
      end

      if (run_clr) begin
        run_q <= 1'b0;
      end

      // Apply uses the shadow values as they stood before this edge.
      if (apply_now) begin
        sigma_out      <= sigma_sh;
        beta_out       <= beta_sh;
        rho_out        <= rho_sh;
        commit_pending <= 1'b0;
      end

      // Software writes come last so a fresh commit request is not lost
      // to a simultaneous apply, and a run write overrides the hardware clear.
      if (wr_ctrl) begin
        run_q <= writedata[0];
      end
      if (wr_commit) begin
        commit_pending <= 1'b1;
      end
      if (wr) begin
        case (address)
          A_SIGMA: sigma_sh   <= writedata;
          A_BETA:  beta_sh    <= writedata;
          A_RHO:   rho_sh     <= writedata;
          A_LIMIT: step_limit <= CNT_W'(writedata);
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      A_CTRL:   readdata[0] = run_q;
      A_SIGMA:  readdata = sigma_sh;
      A_BETA:   readdata = beta_sh;
      A_RHO:    readdata = rho_sh;
      A_LIMIT:  readdata = DATA_W'(step_limit);
      A_STATUS: begin
        readdata[0]   = running;
        readdata[1]   = commit_pending;
        readdata[4:2] = state;
      end
      A_COUNT:  readdata = DATA_W'(step_count);
      default:  readdata = '0;
    endcase
  end

endmodule
